// File: rtl/draw_sequencer.sv
// draw_sequencer: grants one of three full-screen drawers at a time, muxes its pixel stream to the VGA port.
// Optional DRAW_WATCHDOG_EN adds an ACTIVE-state timeout and a sticky timeout_err output.
module draw_sequencer #(
  parameter int NUM_SRC = 3
`ifdef DRAW_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 40000
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [3*NUM_SRC-1:0] src_col,
  input  logic [8*NUM_SRC-1:0] src_x,
  input  logic [7*NUM_SRC-1:0] src_y,
  input  logic [NUM_SRC-1:0]   src_plot,
  input  logic [NUM_SRC-1:0]   src_done,
  output logic [NUM_SRC-1:0]   src_en,
  output logic [2:0]           vga_colour,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_id
`ifdef DRAW_WATCHDOG_EN
  , output logic               timeout_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RELEASE
  } state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [1:0]         sel_q;
  logic [NUM_SRC-1:0] src_en_q;
  logic [2:0]         col_q;
  logic [7:0]         x_q;
  logic [6:0]         y_q;
  logic               plot_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         done_id_q;

  logic               gnt_vld;
  logic [1:0]         gnt_id;
  logic [NUM_SRC-1:0] gnt_oh;
  logic               gnt_fire;

  logic [2:0]         m_col;
  logic [7:0]         m_x;
  logic [6:0]         m_y;
  logic               m_plot;
  logic               m_done;

`ifdef DRAW_WATCHDOG_EN
  logic [15:0]        wd_cnt_q;
  logic               tmo_q;
`endif

  // Fixed-priority pick: gameover > clear > frame
  always_comb begin
    gnt_vld = 1'b1;
    gnt_id  = 2'd0;
    if (pending_q[1])      gnt_id = 2'd1;
    else if (pending_q[0]) gnt_id = 2'd0;
    else if (pending_q[2]) gnt_id = 2'd2;
    else                   gnt_vld = 1'b0;
  end

  assign gnt_fire  = (state_q == S_IDLE) && gnt_vld;
  assign gnt_oh    = NUM_SRC'(1) << gnt_id;
  assign pending_d = (pending_q | req) & ~(gnt_fire ? gnt_oh : '0);

  // Select the pixel stream of the granted drawer
  always_comb begin
    m_col  = src_col[2:0];
    m_x    = src_x[7:0];
    m_y    = src_y[6:0];
    m_plot = src_plot[0];
    m_done = src_done[0];
    case (sel_q)
      2'd1: begin
        m_col  = src_col[5:3];
        m_x    = src_x[15:8];
        m_y    = src_y[13:7];
        m_plot = src_plot[1];
        m_done = src_done[1];
      end
      2'd2: begin
        m_col  = src_col[8:6];
        m_x    = src_x[23:16];
        m_y    = src_y[20:14];
        m_plot = src_plot[2];
        m_done = src_done[2];
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered enables, pixel stage and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      sel_q     <= 2'd0;
      src_en_q  <= '0;
      col_q     <= 3'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 2'd0;
`ifdef DRAW_WATCHDOG_EN
      wd_cnt_q  <= 16'd0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (gnt_vld) begin
            sel_q    <= gnt_id;
            src_en_q <= gnt_oh;
            busy_q   <= 1'b1;
            state_q  <= S_ACTIVE;
`ifdef DRAW_WATCHDOG_EN
            wd_cnt_q <= 16'd0;
`endif
          end
        end
        S_ACTIVE: begin
          col_q  <= m_col;
          x_q    <= m_x;
          y_q    <= m_y;
          plot_q <= m_plot & ~m_done;
          if (m_done) begin
            src_en_q  <= '0;
            done_q    <= 1'b1;
            done_id_q <= sel_q;
            state_q   <= S_RELEASE;
          end
`ifdef DRAW_WATCHDOG_EN
          else if (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            src_en_q  <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b1;
            done_id_q <= sel_q;
            tmo_q     <= 1'b1;
            state_q   <= S_RELEASE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
          end
`endif
        end
        S_RELEASE: begin
          plot_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src_en     = src_en_q;
  assign vga_colour = col_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
`ifdef DRAW_WATCHDOG_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Sits between the game control FSM and the VGA adapter.
- Arbitrates three full-screen drawers: clear, gameover, frame. Each drawer has enable/col/x/y/plot_go/completed semantics like the gameover drawer.
- Enables one drawer at a time and muxes its pixel stream onto the single VGA plot port through one register stage.
- Reports completion back to control with a one-cycle done pulse.

Parameters:
- NUM_SRC, 3, number of drawer sources. Fixed at 3; index 0 = clear, 1 = gameover, 2 = frame.
- TIMEOUT_CYCLES, 40000, watchdog limit in clk cycles. Used only with DRAW_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  3  request strobes, one bit per source; sampled every cycle
- src_col  in  9  {frame[8:6], gameover[5:3], clear[2:0]} colours
- src_x  in  24  {frame, gameover, clear} x, 8 bits each
- src_y  in  21  {frame, gameover, clear} y, 7 bits each
- src_plot  in  3  per-source plot_go
- src_done  in  3  per-source completed
- src_en  out  3  one-hot enable to drawers
- vga_colour  out  3  registered colour
- vga_x  out  8  registered x
- vga_y  out  7  registered y
- vga_plot  out  1  registered write strobe
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- done_id  out  2  index of the source that finished; valid with done
- timeout_err  out  1  sticky watchdog flag; only present with DRAW_WATCHDOG_EN

Behaviour:
- Reset: state IDLE, pending=0, sel=0, src_en=0, vga_colour/x/y=0, vga_plot=0, busy=0, done=0, done_id=0, timeout_err=0.
- Pending: each cycle pending <= pending | req. A bit is cleared when its source is granted. A request for a source that is currently active is kept pending and serviced again afterwards.
- IDLE:
  - If pending != 0, grant by fixed priority: gameover(1) > clear(0) > frame(2).
  - Latch sel, clear that pending bit, go to ACTIVE.
  - busy goes high the cycle after the grant decision.
- ACTIVE:
  - src_en = one-hot(sel).
  - The mux registers src_col/x/y[sel] into vga_* every cycle (latency 1).
  - vga_plot <= src_plot[sel] & ~src_done[sel].
  - When src_done[sel]=1, go to RELEASE. No pixel from that cycle is plotted.
- RELEASE (exactly 1 cycle):
  - src_en=0, vga_plot=0, done=1, done_id=sel.
  - Then go to IDLE. This guarantees enable low for at least one cycle, so each drawer clears its counter and its sticky completed flag.
- Back-to-back: a new grant can occur in the IDLE cycle that follows RELEASE. Minimum gap between drawers is 2 cycles with enable low.
- Simultaneous requests: all are latched and served sequentially in priority order.
- A req arriving in the same cycle as RELEASE is latched and not lost.
- src_done on a non-selected source is ignored.
- Reset mid-draw: returns to IDLE next cycle with all outputs at reset values. Pending requests are discarded.
- vga_x/vga_y are pass-through widths; no arithmetic.

Optional Feature:
- DRAW_WATCHDOG_EN defined:
  - A 16-bit counter clears on grant and increments in ACTIVE.
  - When it reaches TIMEOUT_CYCLES-1 without src_done, go to RELEASE (done pulses, done_id=sel) and set timeout_err=1.
  - timeout_err stays set until reset.
- DRAW_WATCHDOG_EN undefined: no counter and no timeout_err port; ACTIVE waits indefinitely.

Test Plan:
- Reset, then req=3'b010 for 1 cycle: src_en=3'b010 from the cycle after the grant. Drive src_plot[1]=1 with x=5, y=3, col=4: vga_x=5, vga_y=3, vga_colour=4, vga_plot=1 one cycle later. Assert src_done[1]: vga_plot=0 and done=1 with done_id=1 on the RELEASE cycle, src_en=0.
- req=3'b111 in one cycle: service order is 1, 0, 2; three done pulses with done_id 1, 0, 2. src_en is low for at least 1 cycle between each pair.
- During an active clear (sel=0), pulse src_done[2]=1: no transition. Then pulse req[0]: clear is redrawn after the current one completes.
- Assert reset while ACTIVE mid-stream: next cycle src_en=0, vga_plot=0, busy=0, and no done pulse follows.
- Assert src_done[sel] while src_plot=1 with x=200: vga_plot stays 0 and no write at x=200.
- With DRAW_WATCHDOG_EN and TIMEOUT_CYCLES=16: grant source 2 and never assert done. Exactly 16 cycles after the grant, done=1, done_id=2, timeout_err=1, and it stays 1 through a subsequent normal draw.
